// File: rtl/sn76489_register_interface.sv
// SN76489 CPU write decoder: latch/data byte protocol into the PSG register file,
// plus the READY wait window that follows every accepted write.
module sn76489_register_interface #(
  parameter int WRITE_WAIT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       write_dropped,
  output logic [9:0] tone0_n,
  output logic [9:0] tone1_n,
  output logic [9:0] tone2_n,
  output logic [9:0] noise_n,
  output logic       noise_feedback_type,
  output logic       noise_reset,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3
);

  localparam int CNT_W = (WRITE_WAIT_CYCLES > 1) ? $clog2(WRITE_WAIT_CYCLES) : 1;
  localparam bit WAIT_EN = (WRITE_WAIT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'((WRITE_WAIT_CYCLES > 0) ? WRITE_WAIT_CYCLES - 1 : 0);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [9:0] r_tone0, r_tone1, r_tone2;
  logic [2:0] r_noise_ctrl;
  logic [3:0] r_att [4];
  logic [1:0] r_latch_chan;
  logic       r_latch_type;
  logic       r_noise_reset;
  logic       r_write_dropped;

  logic       w_ready;
  logic       w_accept;
  logic       w_is_latch;
  logic [1:0] w_chan;
  logic       w_type;
  logic       w_noise_tgt;

  assign w_ready     = (r_state == ST_IDLE);
  assign w_accept    = wr_en && w_ready;
  assign w_is_latch  = wr_data[7];
  // A latch byte addresses its own target; a data byte reuses the stored latch.
  assign w_chan      = w_is_latch ? wr_data[6:5] : r_latch_chan;
  assign w_type      = w_is_latch ? wr_data[4]   : r_latch_type;
  assign w_noise_tgt = (w_chan == 2'd3) && !w_type;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && WAIT_EN) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tone0         <= '0;
      r_tone1         <= '0;
      r_tone2         <= '0;
      r_noise_ctrl    <= 3'b000;
      r_att[0]        <= 4'hF;
      r_att[1]        <= 4'hF;
      r_att[2]        <= 4'hF;
      r_att[3]        <= 4'hF;
      r_latch_chan    <= 2'd0;
      r_latch_type    <= 1'b0;
      r_noise_reset   <= 1'b0;
      r_write_dropped <= 1'b0;
    end else begin
      r_noise_reset   <= w_accept && w_noise_tgt;
      r_write_dropped <= wr_en && !w_ready;
      if (w_accept) begin
        if (w_is_latch) begin
          r_latch_chan <= wr_data[6:5];
          r_latch_type <= wr_data[4];
        end
        if (w_type) begin
          r_att[w_chan] <= wr_data[3:0];
        end else if (w_chan == 2'd3) begin
          r_noise_ctrl <= wr_data[2:0];
        end else if (w_is_latch) begin
          case (w_chan)
            2'd0:    r_tone0[3:0] <= wr_data[3:0];
            2'd1:    r_tone1[3:0] <= wr_data[3:0];
            2'd2:    r_tone2[3:0] <= wr_data[3:0];
            default: ;
          endcase
        end else begin
          case (w_chan)
            2'd0:    r_tone0[9:4] <= wr_data[5:0];
            2'd1:    r_tone1[9:4] <= wr_data[5:0];
            2'd2:    r_tone2[9:4] <= wr_data[5:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Rate 3 follows tone2 live so later tone2 writes retune the noise immediately.
  always_comb begin
    case (r_noise_ctrl[1:0])
      2'b00:   noise_n = 10'h010;
      2'b01:   noise_n = 10'h020;
      2'b10:   noise_n = 10'h040;
      default: noise_n = r_tone2;
    endcase
  end

  assign noise_feedback_type = r_noise_ctrl[2];
  assign ready               = w_ready;
  assign write_dropped       = r_write_dropped;
  assign noise_reset         = r_noise_reset;
  assign tone0_n             = r_tone0;
  assign tone1_n             = r_tone1;
  assign tone2_n             = r_tone2;
  assign att0                = r_att[0];
  assign att1                = r_att[1];
  assign att2                = r_att[2];
  assign att3                = r_att[3];

endmodule

// File: tb/tb_sn76489_register_interface.sv
// Directed bench for the SN76489 register interface: one instance with no wait
// window, one with the default 32-cycle window.
module tb_sn76489_register_interface;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_wr_en;
  logic [7:0] a_wr_data;
  logic       a_ready, a_dropped, a_fb, a_nrst;
  logic [9:0] a_t0, a_t1, a_t2, a_nn;
  logic [3:0] a_at0, a_at1, a_at2, a_at3;

  logic       b_rst_n, b_wr_en;
  logic [7:0] b_wr_data;
  logic       b_ready, b_dropped, b_fb, b_nrst;
  logic [9:0] b_t0, b_t1, b_t2, b_nn;
  logic [3:0] b_at0, b_at1, b_at2, b_at3;

  sn76489_register_interface #(.WRITE_WAIT_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(a_rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .ready(a_ready), .write_dropped(a_dropped),
    .tone0_n(a_t0), .tone1_n(a_t1), .tone2_n(a_t2), .noise_n(a_nn),
    .noise_feedback_type(a_fb), .noise_reset(a_nrst),
    .att0(a_at0), .att1(a_at1), .att2(a_at2), .att3(a_at3)
  );

  sn76489_register_interface dut_b (
    .clk(clk), .reset_n(b_rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .ready(b_ready), .write_dropped(b_dropped),
    .tone0_n(b_t0), .tone1_n(b_t1), .tone2_n(b_t2), .noise_n(b_nn),
    .noise_feedback_type(b_fb), .noise_reset(b_nrst),
    .att0(b_at0), .att1(b_at1), .att2(b_at2), .att3(b_at3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the negedge after the sampling edge.
  task automatic write_a(input logic [7:0] d);
    @(negedge clk);
    a_wr_en = 1'b1;
    a_wr_data = d;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    @(negedge clk);
    b_wr_en = 1'b1;
    b_wr_data = d;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic wait_ready_b;
    int n;
    n = 0;
    while (!b_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) check("b_ready_timeout", 16'(b_ready), 16'd1);
  endtask

  initial begin
    int lows, drops;
    a_rst_n = 1'b0; a_wr_en = 1'b0; a_wr_data = 8'h00;
    b_rst_n = 1'b0; b_wr_en = 1'b0; b_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);

    check("rst_tone0", 16'(a_t0), 16'h000);
    check("rst_tone1", 16'(a_t1), 16'h000);
    check("rst_tone2", 16'(a_t2), 16'h000);
    check("rst_att",   {a_at3, a_at2, a_at1, a_at0}, 16'hFFFF);
    check("rst_noise_n", 16'(a_nn), 16'h010);
    check("rst_fb",    16'(a_fb), 16'd0);
    check("rst_ready", 16'(a_ready), 16'd1);
    check("rst_nrst",  16'(a_nrst), 16'd0);
    check("rst_drop",  16'(a_dropped), 16'd0);

    // Zero-wait instance: tone and attenuation latch/data protocol
    write_a(8'h8E);
    check("t0_low", 16'(a_t0), 16'h00E);
    write_a(8'h0F);
    check("t0_full", 16'(a_t0), 16'h0FE);
    write_a(8'h9A);
    check("att0_latch", 16'(a_at0), 16'hA);
    write_a(8'h15);
    check("att0_data", 16'(a_at0), 16'h5);
    check("t0_kept", 16'(a_t0), 16'h0FE);
    check("a_ready_hi", 16'(a_ready), 16'd1);

    // Noise control and tone2 tracking
    write_a(8'hE7);
    check("fb_white", 16'(a_fb), 16'd1);
    check("nn_tone2_0", 16'(a_nn), 16'h000);
    check("nrst_pulse1", 16'(a_nrst), 16'd1);
    @(negedge clk);
    check("nrst_one_cycle", 16'(a_nrst), 16'd0);
    write_a(8'hC3);
    check("nrst_none_c3", 16'(a_nrst), 16'd0);
    write_a(8'h12);
    check("t2_123", 16'(a_t2), 16'h123);
    check("nn_123", 16'(a_nn), 16'h123);
    check("nrst_none_12", 16'(a_nrst), 16'd0);
    write_a(8'h01);
    check("t2_013", 16'(a_t2), 16'h013);
    check("nn_013", 16'(a_nn), 16'h013);
    check("nrst_none_01", 16'(a_nrst), 16'd0);
    write_a(8'hE4);
    check("nn_e4", 16'(a_nn), 16'h010);
    check("fb_e4", 16'(a_fb), 16'd1);
    check("nrst_e4", 16'(a_nrst), 16'd1);
    write_a(8'h45);
    check("nn_data", 16'(a_nn), 16'h020);
    check("nrst_data", 16'(a_nrst), 16'd1);
    check("a_no_drop", 16'(a_dropped), 16'd0);

    // Zero-wait instance accepts back-to-back bytes
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_data = 8'hA8;
    @(negedge clk);
    a_wr_data = 8'h2C;
    @(negedge clk);
    a_wr_en = 1'b0;
    check("t1_b2b", 16'(a_t1), 16'h2C8);
    check("a_b2b_drop", 16'(a_dropped), 16'd0);

    // Default instance: wait window and dropped writes
    write_b(8'hF2);
    check("b_att3_2", 16'(b_at3), 16'h2);
    check("b_ready_lo", 16'(b_ready), 16'd0);
    wait_ready_b();
    write_b(8'h80);
    b_wr_en = 1'b1;
    b_wr_data = 8'hFF;
    lows = 0;
    drops = 0;
    for (int k = 0; k < 33; k++) begin
      if (!b_ready) lows++;
      @(negedge clk);
      if (b_dropped) drops++;
    end
    b_wr_en = 1'b0;
    check("wait_len", 16'(lows), 16'd32);
    check("drop_cnt", 16'(drops), 16'd32);
    check("b_att3_F", 16'(b_at3), 16'hF);
    check("b_rewait", 16'(b_ready), 16'd0);
    @(negedge clk);
    check("b_drop_clear", 16'(b_dropped), 16'd0);

    // Reset in the middle of a wait window
    wait_ready_b();
    write_b(8'h8A);
    wait_ready_b();
    write_b(8'hB3);
    wait_ready_b();
    write_b(8'hE6);
    check("b_t0_prog", 16'(b_t0), 16'h00A);
    check("b_att1_prog", 16'(b_at1), 16'h3);
    check("b_nn_prog", 16'(b_nn), 16'h040);
    check("b_nrst_prog", 16'(b_nrst), 16'd1);
    repeat (3) @(negedge clk);
    b_rst_n = 1'b0;
    b_wr_en = 1'b1;
    b_wr_data = 8'h9C;
    @(negedge clk);
    b_rst_n = 1'b1;
    b_wr_en = 1'b0;
    check("mid_t0", 16'(b_t0), 16'h000);
    check("mid_att", {b_at3, b_at2, b_at1, b_at0}, 16'hFFFF);
    check("mid_nn", 16'(b_nn), 16'h010);
    check("mid_fb", 16'(b_fb), 16'd0);
    check("mid_nrst", 16'(b_nrst), 16'd0);
    @(negedge clk);
    check("mid_ready", 16'(b_ready), 16'd1);
    write_b(8'h3F);
    check("mid_t0_3f0", 16'(b_t0), 16'h3F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
